// File: rtl/flag_unit_pkg.sv
// Shared encodings for the condition-code path: ALU op codes, NZCV bit
// positions inside the flags vector, and bit positions of the flag_w
// write-enable pair.
package flag_unit_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_ctrl_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // flag_w[1] enables the N,Z pair, flag_w[0] enables the C,V pair
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/flag_unit_if.sv
// Bus between the core control/datapath and flag_unit.
// master = core side (drives ALU info and strobes), slave = flag_unit.
interface flag_unit_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic [1:0]       flag_w;
  logic             cond_sample;
  logic             cond_ex;
  logic             pcs;
  logic             reg_w;
  logic             mem_w;
  logic             next_pc;
  logic [3:0]       flags;
  logic             cond_ex_q;
  logic             pc_write;
  logic             reg_write;
  logic             mem_write;
  logic [CNT_W-1:0] skip_count;

  modport master (
    output alu_a, alu_b, alu_control, alu_result, flag_w, cond_sample,
           cond_ex, pcs, reg_w, mem_w, next_pc,
    input  flags, cond_ex_q, pc_write, reg_write, mem_write, skip_count
  );

  modport slave (
    input  alu_a, alu_b, alu_control, alu_result, flag_w, cond_sample,
           cond_ex, pcs, reg_w, mem_w, next_pc,
    output flags, cond_ex_q, pc_write, reg_write, mem_write, skip_count
  );
endinterface

// File: rtl/flag_gen.sv
// Combinational NZCV generation from ALU operands, result and op code.
// Carry/overflow are rebuilt from a local adder so the ALU does not need
// to export its internal carry; logical ops clear C and V.
module flag_gen
  import flag_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] result,
  input  logic [1:0]       ctrl,
  output logic [3:0]       nzcv
);
  logic             arith;
  logic             sub;
  logic [WIDTH-1:0] bp;
  logic [WIDTH:0]   sum;

  assign arith = (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  assign sub   = (ctrl == ALU_SUB);
  assign bp    = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, bp} + (WIDTH+1)'(sub);

  // NZCV assembly; only the carry-out of the adder matters here
  always_comb begin
    nzcv         = 4'b0000;
    nzcv[FLAG_N] = result[WIDTH-1];
    nzcv[FLAG_Z] = (result == '0);
    if (arith) begin
      nzcv[FLAG_C] = |(sum >> WIDTH);
      nzcv[FLAG_V] = ~(a[WIDTH-1] ^ bp[WIDTH-1]) & (a[WIDTH-1] ^ result[WIDTH-1]);
    end
  end
endmodule

// File: rtl/flag_unit.sv
// Architectural NZCV register, condition-verdict latch, write-strobe gating
// and squashed-instruction counter.
// Optional macro FLAG_FWD_EN: flags output shows the post-write value in the
// same cycle as an enabled write (register behaviour unchanged).
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic       clk,
  input logic       reset_n,
  flag_unit_if.slave fu
);
  logic [3:0]       nzcv;
  logic [3:0]       flags_q;
  logic [3:0]       flags_nxt;
  logic             cond_q;
  logic [CNT_W-1:0] skip_q;

  flag_gen #(.WIDTH(WIDTH)) u_gen (
    .a      (fu.alu_a),
    .b      (fu.alu_b),
    .result (fu.alu_result),
    .ctrl   (fu.alu_control),
    .nzcv   (nzcv)
  );

  // Next flag value: each half written only when the latched verdict passes.
  // Gating on the registered verdict keeps flags->cond_ex->flags loop-free.
  always_comb begin
    flags_nxt = flags_q;
    if (fu.flag_w[FLAGW_NZ] && cond_q) begin
      flags_nxt[FLAG_N] = nzcv[FLAG_N];
      flags_nxt[FLAG_Z] = nzcv[FLAG_Z];
    end
    if (fu.flag_w[FLAGW_CV] && cond_q) begin
      flags_nxt[FLAG_C] = nzcv[FLAG_C];
      flags_nxt[FLAG_V] = nzcv[FLAG_V];
    end
  end

  // Flags register, verdict latch and saturating skip counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
      cond_q  <= 1'b0;
      skip_q  <= '0;
    end else begin
      flags_q <= flags_nxt;
      if (fu.cond_sample) begin
        cond_q <= fu.cond_ex;
        if (!fu.cond_ex && (skip_q != '1))
          skip_q <= skip_q + CNT_W'(1);
      end
    end
  end

`ifdef FLAG_FWD_EN
  assign fu.flags = flags_nxt;
`else
  assign fu.flags = flags_q;
`endif

  assign fu.cond_ex_q  = cond_q;
  assign fu.skip_count = skip_q;
  assign fu.pc_write   = (fu.pcs & cond_q) | fu.next_pc;
  assign fu.reg_write  = fu.reg_w & cond_q;
  assign fu.mem_write  = fu.mem_w & cond_q;
endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit (CNT_W=4 so saturation is reachable quickly).
module tb_flag_unit;
  import flag_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  flag_unit_if #(.WIDTH(32), .CNT_W(4)) bus ();

  flag_unit #(.WIDTH(32), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fu      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.alu_a = '0; bus.alu_b = '0; bus.alu_control = ALU_ADD; bus.alu_result = '0;
    bus.flag_w = 2'b00; bus.cond_sample = 1'b0; bus.cond_ex = 1'b0;
    bus.pcs = 1'b0; bus.reg_w = 1'b0; bus.mem_w = 1'b0; bus.next_pc = 1'b0;
  endtask

  // one flag-write cycle; write enables dropped before observing flags
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                       input logic [31:0] r, input logic [1:0] fw);
    @(negedge clk);
    bus.alu_a = a; bus.alu_b = b; bus.alu_control = c; bus.alu_result = r; bus.flag_w = fw;
    @(posedge clk); #1;
    bus.flag_w = 2'b00;
    #1;
  endtask

  task automatic sample(input logic ex);
    @(negedge clk);
    bus.cond_sample = 1'b1; bus.cond_ex = ex;
    @(posedge clk); #1;
    bus.cond_sample = 1'b0; bus.cond_ex = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", bus.flags); end
    checks++; if (bus.cond_ex_q !== 1'b0) begin failures++; $display("FAIL reset_cond got=%b exp=0", bus.cond_ex_q); end
    checks++; if (bus.skip_count !== 4'd0) begin failures++; $display("FAIL reset_skip got=%0d exp=0", bus.skip_count); end
    checks++; if ({bus.pc_write, bus.reg_write, bus.mem_write} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {bus.pc_write, bus.reg_write, bus.mem_write}); end
    reset_n = 1'b1;
  endtask

  task automatic test_pass_strobes();
    sample(1'b1);
    checks++; if (bus.cond_ex_q !== 1'b1) begin failures++; $display("FAIL pass_cond got=%b exp=1", bus.cond_ex_q); end
    checks++; if (bus.skip_count !== 4'd0) begin failures++; $display("FAIL pass_skip got=%0d exp=0", bus.skip_count); end
    bus.reg_w = 1'b1; bus.mem_w = 1'b1; bus.pcs = 1'b1; #1;
    checks++; if ({bus.pc_write, bus.reg_write, bus.mem_write} !== 3'b111) begin failures++; $display("FAIL pass_strobes got=%b exp=111", {bus.pc_write, bus.reg_write, bus.mem_write}); end
    clear_inputs(); #1;
  endtask

  task automatic test_sub_zero();
    apply(32'd5, 32'd5, ALU_SUB, 32'd0, 2'b11);
    checks++; if (bus.flags !== 4'b0110) begin failures++; $display("FAIL sub_zero got=%b exp=0110", bus.flags); end
  endtask

  task automatic test_add_overflow();
    apply(32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000, 2'b11);
    checks++; if (bus.flags !== 4'b1001) begin failures++; $display("FAIL add_ovf got=%b exp=1001", bus.flags); end
    apply(32'h0000_00F0, 32'h0000_000F, ALU_AND, 32'd0, 2'b10);
    checks++; if (bus.flags !== 4'b0101) begin failures++; $display("FAIL and_nz_only got=%b exp=0101", bus.flags); end
    apply(32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'd0, 2'b01);
    checks++; if (bus.flags !== 4'b0110) begin failures++; $display("FAIL add_cv_only got=%b exp=0110", bus.flags); end
    apply(32'h1234_5678, 32'h0F0F_0F0F, ALU_ORR, 32'h1F3F_5F7F, 2'b00);
    checks++; if (bus.flags !== 4'b0110) begin failures++; $display("FAIL hold_no_wr got=%b exp=0110", bus.flags); end
  endtask

  task automatic test_squash();
    sample(1'b0);
    checks++; if (bus.cond_ex_q !== 1'b0) begin failures++; $display("FAIL squash_cond got=%b exp=0", bus.cond_ex_q); end
    checks++; if (bus.skip_count !== 4'd1) begin failures++; $display("FAIL squash_skip got=%0d exp=1", bus.skip_count); end
    bus.reg_w = 1'b1; bus.mem_w = 1'b1; bus.pcs = 1'b1; #1;
    checks++; if ({bus.pc_write, bus.reg_write, bus.mem_write} !== 3'b000) begin failures++; $display("FAIL squash_strobes got=%b exp=000", {bus.pc_write, bus.reg_write, bus.mem_write}); end
    bus.next_pc = 1'b1; #1;
    checks++; if (bus.pc_write !== 1'b1) begin failures++; $display("FAIL next_pc_force got=%b exp=1", bus.pc_write); end
    clear_inputs();
    apply(32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000, 2'b11);
    checks++; if (bus.flags !== 4'b0110) begin failures++; $display("FAIL squash_flags got=%b exp=0110", bus.flags); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bus.alu_a = 32'h8000_0001; bus.alu_b = 32'h8000_0000; bus.alu_control = ALU_AND;
    bus.alu_result = 32'h8000_0000; bus.flag_w = 2'b11; bus.cond_sample = 1'b1; bus.cond_ex = 1'b1;
    @(posedge clk); #1;
    clear_inputs(); #1;
    checks++; if (bus.flags !== 4'b0110) begin failures++; $display("FAIL same_cycle_flags got=%b exp=0110", bus.flags); end
    checks++; if (bus.cond_ex_q !== 1'b1) begin failures++; $display("FAIL same_cycle_cond got=%b exp=1", bus.cond_ex_q); end
    checks++; if (bus.skip_count !== 4'd1) begin failures++; $display("FAIL same_cycle_skip got=%0d exp=1", bus.skip_count); end
    apply(32'h8000_0001, 32'h8000_0000, ALU_AND, 32'h8000_0000, 2'b11);
    checks++; if (bus.flags !== 4'b1000) begin failures++; $display("FAIL after_verdict got=%b exp=1000", bus.flags); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 20; k++) begin
      sample(1'b0);
      checks++;
      if (bus.skip_count !== ((k + 2 > 15) ? 4'd15 : 4'(k + 2))) begin
        failures++; $display("FAIL sat_step%0d got=%0d exp=%0d", k, bus.skip_count, (k + 2 > 15) ? 15 : k + 2);
      end
    end
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.skip_count !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", bus.skip_count); end
  endtask

  task automatic test_reset_async();
    sample(1'b1);
    checks++; if (bus.cond_ex_q !== 1'b1) begin failures++; $display("FAIL pre_rst_cond got=%b exp=1", bus.cond_ex_q); end
    @(negedge clk);
    bus.alu_a = 32'd5; bus.alu_b = 32'd5; bus.alu_control = ALU_SUB; bus.alu_result = 32'd0;
    bus.flag_w = 2'b11; bus.cond_sample = 1'b1; bus.cond_ex = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.flags !== 4'b0000) begin failures++; $display("FAIL async_flags got=%b exp=0000", bus.flags); end
    checks++; if (bus.cond_ex_q !== 1'b0) begin failures++; $display("FAIL async_cond got=%b exp=0", bus.cond_ex_q); end
    checks++; if (bus.skip_count !== 4'd0) begin failures++; $display("FAIL async_skip got=%0d exp=0", bus.skip_count); end
    @(posedge clk); #1;
    checks++; if ({bus.flags, bus.cond_ex_q, bus.skip_count} !== 9'd0) begin failures++; $display("FAIL rst_hold got=%b exp=0", {bus.flags, bus.cond_ex_q, bus.skip_count}); end
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_pass_strobes();
    test_sub_zero();
    test_add_overflow();
    test_squash();
    test_same_cycle();
    test_saturation();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
